// File: rtl/freq_sort_if.sv
// ----------------------------------------------------------------------------
// freq_sort_if
//   Bundle between the symbol frequency counter and the frequency sorter.
//   The counter side (master) presents the packed {freq,sym} table with
//   count_over. The sorter side (slave) returns the sorted table and the
//   sticky sort_over flag.
//
//   Signals
//     count_over   master->slave  counter finished; FREQUENT_IN valid while high
//     FREQUENT_IN  master->slave  N_SYM entries, entry k = {freq, sym}
//     SORTED_OUT   slave->master  sorted table, entry 0 = smallest
//     sort_over    slave->master  sort complete; SORTED_OUT valid while high
// ----------------------------------------------------------------------------
interface freq_sort_if #(
    parameter int N_SYM  = 10,
    parameter int FREQ_W = 8,
    parameter int SYM_W  = 5
);
    localparam int EW = FREQ_W + SYM_W;

    logic                  count_over;
    logic [N_SYM*EW-1:0]   FREQUENT_IN;
    logic [N_SYM*EW-1:0]   SORTED_OUT;
    logic                  sort_over;

    modport master (
        output count_over,
        output FREQUENT_IN,
        input  SORTED_OUT,
        input  sort_over
    );

    modport slave (
        input  count_over,
        input  FREQUENT_IN,
        output SORTED_OUT,
        output sort_over
    );
endinterface

// File: rtl/freq_sort.sv
// ----------------------------------------------------------------------------
// freq_sort
//   Captures the {frequency,symbol} table from the frequency counter when
//   count_over is seen, sorts it into ascending order with an odd-even
//   transposition network (one pass per clock, N_SYM passes), then holds the
//   result with a sticky sort_over flag until reset.
//
//   Ports
//     CLK   input   rising-edge clock
//     nRST  input   synchronous active-low reset
//     bus   freq_sort_if.slave (count_over, FREQUENT_IN in;
//                               SORTED_OUT, sort_over out)
//
//   Configuration macro
//     FREQ_SORT_ZERO_LAST_EN : when defined, freq==0 entries rank above every
//     nonzero freq so unused symbols collect at the top of the table.
// ----------------------------------------------------------------------------
module freq_sort #(
    parameter int N_SYM  = 10,
    parameter int FREQ_W = 8,
    parameter int SYM_W  = 5
) (
    input  logic         CLK,
    input  logic         nRST,
    freq_sort_if.slave   bus
);
    localparam int EW    = FREQ_W + SYM_W;
    localparam int CNT_W = $clog2(N_SYM) + 1;
    localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(N_SYM - 1);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_passCnt;
    logic [EW-1:0]       r_table [N_SYM];
    logic                r_sortOver;
    logic [EW-1:0]       w_passed [N_SYM];

    // Entry layout {freq, sym} already orders by freq then sym, so a plain
    // unsigned compare of the whole entry implements the tie-break. The zero-last
    // build prepends a "freq is zero" bit so those entries outrank everything.
    function automatic logic needSwap(input logic [EW-1:0] a, input logic [EW-1:0] b);
`ifdef FREQ_SORT_ZERO_LAST_EN
        return {(a[EW-1 -: FREQ_W] == '0), a} > {(b[EW-1 -: FREQ_W] == '0), b};
`else
        return a > b;
`endif
    endfunction

    // One transposition pass: the pass counter's parity selects whether the
    // pairs start at entry 0 or entry 1. Pairs are disjoint, so every swap
    // reads the registered table. An unpaired end entry passes through.
    always_comb begin
        for (int k = 0; k < N_SYM; k++) begin
            w_passed[k] = r_table[k];
        end
        for (int i = 0; i < N_SYM - 1; i++) begin
            if ((i[0] == r_passCnt[0]) && needSwap(r_table[i], r_table[i+1])) begin
                w_passed[i]   = r_table[i+1];
                w_passed[i+1] = r_table[i];
            end
        end
    end

    // Control FSM and table register. DONE is terminal: only nRST leaves it,
    // so count_over held high after completion never reloads the table.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_passCnt  <= '0;
            r_sortOver <= 1'b0;
            for (int k = 0; k < N_SYM; k++) begin
                r_table[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.count_over) begin
                        for (int k = 0; k < N_SYM; k++) begin
                            r_table[k] <= bus.FREQUENT_IN[EW*k +: EW];
                        end
                        r_passCnt <= '0;
                        r_state   <= SORT;
                    end
                end
                SORT: begin
                    for (int k = 0; k < N_SYM; k++) begin
                        r_table[k] <= w_passed[k];
                    end
                    if (r_passCnt == LAST_PASS) begin
                        r_state    <= DONE;
                        r_sortOver <= 1'b1;
                    end else begin
                        r_passCnt <= r_passCnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The table register drives the output directly.
    for (genvar g = 0; g < N_SYM; g++) begin : g_out
        assign bus.SORTED_OUT[EW*g +: EW] = r_table[g];
    end
    assign bus.sort_over = r_sortOver;

endmodule

// File: tb/tb_freq_sort.sv
// ----------------------------------------------------------------------------
// tb_freq_sort
//   Testbench for freq_sort. Stimulus pushes the expected sorted table and the
//   load edge into a queue; a monitor pops on each rising sort_over and checks
//   table contents and load-to-done latency. Expected tables come from a
//   reference sort computed directly from the ordering rules.
//   Honours FREQ_SORT_ZERO_LAST_EN in the reference model.
// ----------------------------------------------------------------------------
module tb_freq_sort;
    localparam int N_SYM   = 10;
    localparam int FREQ_W  = 8;
    localparam int SYM_W   = 5;
    localparam int EW      = FREQ_W + SYM_W;
    localparam int TW      = N_SYM * EW;
    localparam int LATENCY = N_SYM + 1;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    freq_sort_if #(.N_SYM(N_SYM), .FREQ_W(FREQ_W), .SYM_W(SYM_W)) bus ();

    freq_sort #(.N_SYM(N_SYM), .FREQ_W(FREQ_W), .SYM_W(SYM_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [TW-1:0] tbl;
        int            loadEdge;
    } exp_t;

    exp_t expQ[$];
    int   total     = 0;
    int   bad       = 0;
    int   edgeCount = 0;
    int   doneCount = 0;
    logic prevOver  = 1'b0;

    // Counts rising edges so latency can be measured in edges.
    always @(posedge CLK) edgeCount <= edgeCount + 1;

    // Reference: repeatedly pick the smallest remaining entry by rank
    // (freq, then sym; zero freq ranks highest in the zero-last build).
    function automatic logic [TW-1:0] refSort(input logic [TW-1:0] inTab);
        longint key [N_SYM];
        bit     used[N_SYM];
        logic [TW-1:0] outTab;
        int     best;
        outTab = '0;
        for (int k = 0; k < N_SYM; k++) begin
            longint f, s;
            f = longint'(inTab[EW*k+SYM_W +: FREQ_W]);
            s = longint'(inTab[EW*k +: SYM_W]);
            key[k] = f * 64 + s;
`ifdef FREQ_SORT_ZERO_LAST_EN
            if (f == 0) key[k] += 64'd1 << 20;
`endif
            used[k] = 1'b0;
        end
        for (int pos = 0; pos < N_SYM; pos++) begin
            best = -1;
            for (int k = 0; k < N_SYM; k++) begin
                if (!used[k] && (best < 0 || key[k] < key[best])) best = k;
            end
            used[best] = 1'b1;
            outTab[EW*pos +: EW] = inTab[EW*best +: EW];
        end
        return outTab;
    endfunction

    function automatic logic [EW-1:0] entry(input int f, input int s);
        return {FREQ_W'(f), SYM_W'(s)};
    endfunction

    task automatic checkOutput(input string name, input logic [TW-1:0] actual,
                               input logic [TW-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every rising sort_over must match the oldest queued expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (bus.sort_over === 1'b1 && prevOver !== 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got sort_over=1 expected no completion");
            end else begin
                e = expQ.pop_front();
                checkOutput("sorted_table", bus.SORTED_OUT, e.tbl);
                checkOutput("latency", TW'(edgeCount - e.loadEdge + 1), TW'(LATENCY));
            end
            doneCount++;
        end
        prevOver <= bus.sort_over;
    end

    // Drives a table with count_over; hold=1 keeps count_over high until the
    // caller drops it, otherwise it is a one-cycle pulse.
    task automatic applyStimulus(input logic [TW-1:0] tab, input bit hold, input bit expectDone);
        exp_t e;
        @(negedge CLK);
        bus.FREQUENT_IN = tab;
        bus.count_over  = 1'b1;
        if (expectDone) begin
            e.tbl      = refSort(tab);
            e.loadEdge = edgeCount + 1;
            expQ.push_back(e);
        end
        if (!hold) begin
            @(negedge CLK);
            bus.count_over = 1'b0;
        end
    endtask

    task automatic waitDone(input string name);
        int  target;
        bit  seen;
        target = doneCount + 1;
        seen   = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge CLK);
            #1;
            if (doneCount >= target) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: got no sort_over within 40 cycles expected completion", name);
            expQ.delete();
        end
        bus.count_over = 1'b0;
    endtask

    task automatic doReset();
        @(negedge CLK);
        nRST           = 1'b0;
        bus.count_over = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    function automatic logic [TW-1:0] randTable();
        logic [TW-1:0] t;
        int f;
        for (int k = 0; k < N_SYM; k++) begin
            f = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            t[EW*k +: EW] = entry(f, int'($urandom_range(0, 31)));
        end
        return t;
    endfunction

    initial begin
        logic [TW-1:0] tabAsc, tabDesc, tabTie, tabZero, tabA, expA;
        int zf[N_SYM];

        bus.count_over  = 1'b0;
        bus.FREQUENT_IN = '0;
        zf = '{0, 4, 0, 2, 7, 0, 1, 9, 3, 5};
        for (int k = 0; k < N_SYM; k++) begin
            tabAsc [EW*k +: EW] = entry(k + 1, k + 1);
            tabDesc[EW*k +: EW] = entry(10 - k, k + 1);
            tabTie [EW*k +: EW] = entry(3, 10 - k);
            tabZero[EW*k +: EW] = entry(zf[k], k + 1);
        end

        // Reset state with garbage on the inputs.
        bus.FREQUENT_IN = randTable();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        #1;
        checkOutput("reset_sort_over", TW'(bus.sort_over), TW'(0));
        checkOutput("reset_sorted_out", bus.SORTED_OUT, '0);

        // Ascending, descending and all-equal-frequency tables, count_over held.
        applyStimulus(tabAsc, 1'b1, 1'b1);
        waitDone("ascending");
        doReset();
        applyStimulus(tabDesc, 1'b1, 1'b1);
        waitDone("descending");
        doReset();
        applyStimulus(tabTie, 1'b1, 1'b1);
        waitDone("ties");
        doReset();

        // Abort mid-sort: reset sampled on the 5th pass edge.
        applyStimulus(tabDesc, 1'b1, 1'b0);
        repeat (5) @(negedge CLK);
        nRST           = 1'b0;
        bus.count_over = 1'b0;
        @(negedge CLK);
        #1;
        checkOutput("abort_sort_over", TW'(bus.sort_over), TW'(0));
        checkOutput("abort_sorted_out", bus.SORTED_OUT, '0);
        nRST = 1'b1;
        applyStimulus(tabDesc, 1'b0, 1'b1);
        waitDone("after_abort");
        doReset();

        // Pulse load, then new data and count_over in DONE must not reload.
        tabA = randTable();
        expA = refSort(tabA);
        applyStimulus(tabA, 1'b0, 1'b1);
        waitDone("pulse");
        @(negedge CLK);
        bus.FREQUENT_IN = randTable();
        bus.count_over  = 1'b1;
        repeat (15) @(negedge CLK);
        #1;
        checkOutput("sticky_sort_over", TW'(bus.sort_over), TW'(1));
        checkOutput("sticky_table", bus.SORTED_OUT, expA);
        bus.count_over = 1'b0;
        doReset();

        // Zero-frequency placement.
        applyStimulus(tabZero, 1'b0, 1'b1);
        waitDone("zero_freq");
        doReset();

        // Randomized tables, alternating held and pulsed count_over.
        for (int r = 0; r < 20; r++) begin
            applyStimulus(randTable(), r[0], 1'b1);
            waitDone("random");
            doReset();
        end

        repeat (3) @(negedge CLK);
        checkOutput("queue_drained", TW'(expQ.size()), TW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
